// File: rtl/pipe_mdu_ctrl.sv
// Multi-cycle multiply/divide unit controller for an in-order pipeline.
// Runs a 32-step shift-add multiply or restoring divide on operand magnitudes,
// fixes up signs in a single cycle, then pulses out_done for one cycle.
// The pipeline is frozen through out_stall while an operation is in flight.
module pipe_mdu_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic              in_flush,
  output logic              out_stall,
  output logic              out_busy,
  output logic              out_done,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo,
  output logic              out_div_zero
);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic                is_div_q, is_div_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                dz_q, dz_d;

  logic                rs_neg, rt_neg;
  logic [DATA_W-1:0]   rs_mag, rt_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift, div_diff;
  logic                div_ok;
  logic [2*DATA_W-1:0] prod_fix;
  logic                last_step;

  // Operand magnitudes and per-step datapath terms
  always_comb begin
    rs_neg    = in_op[0] & in_rs_data[DATA_W-1];
    rt_neg    = in_op[0] & in_rt_data[DATA_W-1];
    rs_mag    = rs_neg ? -in_rs_data : in_rs_data;
    rt_mag    = rt_neg ? -in_rt_data : in_rt_data;
    // acc = {partial product hi, multiplier}; multiplier LSB gates the add
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                (acc_q[0] ? {1'b0, opnd_q} : '0);
    // acc = {remainder, quotient/dividend}; shift next dividend bit into remainder
    div_shift = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[DATA_W];
    prod_fix  = qneg_q ? -acc_q : acc_q;
    last_step = (cnt_q == 6'(DATA_W - 1));
  end

  // Next-state, datapath and result register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    unique case (state_q)
      StIdle: begin
        if (in_start) begin
          is_div_d = in_op[1];
          cnt_d    = '0;
          qneg_d   = rs_neg ^ rt_neg;
          rneg_d   = rs_neg;
          opnd_d   = in_op[1] ? rt_mag : rs_mag;
          acc_d    = {{DATA_W{1'b0}}, (in_op[1] ? rs_mag : rt_mag)};
          if (in_op[1] && (in_rt_data == '0)) begin
            state_d = StDone;
            hi_d    = in_rs_data;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else begin
            state_d = in_op[1] ? StDiv : StMul;
            dz_d    = 1'b0;
          end
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        cnt_d = cnt_q + 6'd1;
        if (last_step) state_d = StFix;
      end
      StDiv: begin
        acc_d = {(div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                 acc_q[DATA_W-2:0], div_ok};
        cnt_d = cnt_q + 6'd1;
        if (last_step) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = qneg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          hi_d = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Flush wins over everything, including a start in IDLE, and keeps results
    if (in_flush) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  // Status outputs; stall is forced low while reset is held
  always_comb begin
    out_busy     = (state_q != StIdle);
    out_done     = (state_q == StDone);
    out_stall    = in_rst && (((state_q == StIdle) && in_start) ||
                              (state_q == StMul) || (state_q == StDiv) ||
                              (state_q == StFix));
    out_hi       = hi_q;
    out_lo       = lo_q;
    out_div_zero = dz_q;
  end

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Scoreboard bench for pipe_mdu_ctrl: stimulus pushes reference results,
// a negedge monitor pops and compares whenever out_done is seen.
module tb_pipe_mdu_ctrl;

  logic        in_clk;
  logic        in_rst;
  logic        in_start;
  logic [1:0]  in_op;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        in_flush;
  logic        out_stall;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        out_div_zero;

  pipe_mdu_ctrl #(.DATA_W(32)) dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_start     (in_start),
    .in_op        (in_op),
    .in_rs_data   (in_rs_data),
    .in_rt_data   (in_rt_data),
    .in_flush     (in_flush),
    .out_stall    (out_stall),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_hi       (out_hi),
    .out_lo       (out_lo),
    .out_div_zero (out_div_zero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start_cyc;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        stall_bad = 1'b0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  logic        last_dz = 1'b0;

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the arithmetic definitions
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int sc);
    exp_t    e;
    longint  sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.start_cyc = sc;
    e.done_cyc  = sc + 34;
    e.dz        = 1'b0;
    e.hi        = '0;
    e.lo        = '0;
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'b01: begin
        p = 64'(sa * sb);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.done_cyc = sc + 1;
        end else if (op == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          sq = sa / sb; sr = sa % sb;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    exp_t e;
    @(posedge in_clk); #1;
    in_start = 1'b1; in_op = op; in_rs_data = a; in_rt_data = b;
    if (push) begin
      e = model(op, a, b, cyc);
      q.push_back(e);
      last_hi = e.hi; last_lo = e.lo; last_dz = e.dz;
    end
    @(posedge in_clk); #1;
    in_start = 1'b0; in_rs_data = $urandom; in_rt_data = $urandom;
    in_op = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge in_clk);
      k++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  // Monitor: compare each completion against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge in_clk);
      if (q.size() != 0 && cyc >= q[0].start_cyc && !out_done && !out_stall)
        stall_bad = 1'b1;
      if (out_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("hi", 64'(out_hi), 64'(e.hi));
          chk("lo", 64'(out_lo), 64'(e.lo));
          chk("div_zero", 64'(out_div_zero), 64'(e.dz));
          chk("stall_at_done", 64'(out_stall), 64'd0);
          chk("stall_held", 64'(stall_bad), 64'd0);
          stall_bad = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    in_rst = 1'b0; in_start = 1'b1; in_op = 2'b00; in_flush = 1'b0;
    in_rs_data = '0; in_rt_data = '0;
    #12;
    chk("rst_stall", 64'(out_stall), 64'd0);
    chk("rst_busy", 64'(out_busy), 64'd0);
    chk("rst_done", 64'(out_done), 64'd0);
    chk("rst_hi", 64'(out_hi), 64'd0);
    chk("rst_lo", 64'(out_lo), 64'd0);
    chk("rst_dz", 64'(out_div_zero), 64'd0);
    in_start = 1'b0;
    @(negedge in_clk); in_rst = 1'b1;

    // Directed cases
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); drain();
    issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1);         drain();
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);         drain();
    issue(2'b10, 32'd10, 32'd0, 1'b1);                drain();
    issue(2'b00, 32'd2, 32'd3, 1'b1);                 drain();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain();

    // Start during an operation is ignored
    issue(2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    repeat (9) @(posedge in_clk);
    #1 in_start = 1'b1; in_op = 2'b00; in_rs_data = 32'd7; in_rt_data = 32'd9;
    @(posedge in_clk); #1 in_start = 1'b0;
    drain();
    repeat (3) @(posedge in_clk);

    // Flush mid-operation: back to idle, results untouched, no done
    issue(2'b10, 32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (18) @(posedge in_clk);
    #1 in_flush = 1'b1;
    @(posedge in_clk); #1 in_flush = 1'b0;
    chk("flush_busy", 64'(out_busy), 64'd0);
    chk("flush_hi", 64'(out_hi), 64'(last_hi));
    chk("flush_lo", 64'(out_lo), 64'(last_lo));
    chk("flush_dz", 64'(out_div_zero), 64'(last_dz));
    repeat (40) @(posedge in_clk);

    // Flush in IDLE suppresses a simultaneous start
    #1 in_start = 1'b1; in_flush = 1'b1; in_op = 2'b00;
    @(posedge in_clk); #1 in_start = 1'b0; in_flush = 1'b0;
    chk("flush_idle_busy", 64'(out_busy), 64'd0);
    repeat (40) @(posedge in_clk);

    // Asynchronous reset mid-divide
    issue(2'b10, 32'd1000, 32'd9, 1'b0);
    repeat (13) @(posedge in_clk);
    #1 in_rst = 1'b0; in_start = 1'b1;
    #1;
    chk("arst_hi", 64'(out_hi), 64'd0);
    chk("arst_lo", 64'(out_lo), 64'd0);
    chk("arst_busy", 64'(out_busy), 64'd0);
    chk("arst_done", 64'(out_done), 64'd0);
    chk("arst_dz", 64'(out_div_zero), 64'd0);
    chk("arst_stall", 64'(out_stall), 64'd0);
    in_start = 1'b0;
    @(negedge in_clk); in_rst = 1'b1;
    last_hi = '0; last_lo = '0; last_dz = 1'b0;
    issue(2'b10, 32'd100, 32'd7, 1'b1); drain();

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(0, 10)); end
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = -32'($urandom_range(1, 20)); b = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      issue(op, a, b, 1'b1);
      drain();
    end

    repeat (5) @(posedge in_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mdu_ctrl.md
PIPE_MDU_CTRL -- requirements
Module: pipe_mdu_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_W, default 32, operand width; only 32 is supported.
REQ-003 Port in_clk, input, 1, rising-edge clock.
REQ-004 Port in_rst, input, 1, asynchronous active-low reset.
REQ-005 Port in_start, input, 1, operation request from the EX stage, sampled at the clock edge.
REQ-006 Port in_op, input, 2, operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 Port in_rs_data, input, 32, multiplicand or dividend.
REQ-008 Port in_rt_data, input, 32, multiplier or divisor.
REQ-009 Port in_flush, input, 1, abort of the in-flight operation.
REQ-010 Port out_stall, output, 1, pipeline freeze request to the IF, IF/ID and ID/EX registers.
REQ-011 Port out_busy, output, 1, high while the state is not IDLE.
REQ-012 Port out_done, output, 1, single-cycle completion pulse.
REQ-013 Port out_hi, output, 32, HI register (high product word or remainder).
REQ-014 Port out_lo, output, 32, LO register (low product word or quotient).
REQ-015 Port out_div_zero, output, 1, sticky divide-by-zero flag for the last operation.

Function
REQ-016 The block SHALL implement the states IDLE, MUL, DIV, FIX and DONE.
REQ-017 IDLE with in_start=1: the block SHALL latch operands and op, compute magnitudes for signed ops, latch the result sign, clear the iteration counter, and go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-018 Result sign: product sign = XOR of the operand signs; quotient sign = XOR of the operand signs; remainder sign = dividend sign; unsigned ops SHALL force a positive sign.
REQ-019 MUL SHALL perform one shift-add step per cycle over a 64-bit accumulator, for 32 cycles, with a 6-bit counter.
REQ-020 DIV SHALL perform one restoring shift-subtract step per cycle, for 32 cycles, producing a 32-bit quotient and a 32-bit remainder.
REQ-021 After counter value 31, the block SHALL go to FIX, which applies two's-complement negation as required by REQ-018 and writes out_hi and out_lo.
REQ-022 FIX SHALL go to DONE; DONE SHALL assert out_done for exactly one cycle and then return to IDLE.
REQ-023 Latency: start edge to the out_done cycle SHALL be 34 cycles (32 iterations + FIX + DONE).
REQ-024 out_stall SHALL equal (state==IDLE && in_start) || state in {MUL, DIV, FIX}.
REQ-025 out_stall SHALL be low in DONE, so the stalled consumer advances in the same cycle in which the results are visible.
REQ-026 DIV/DIVU with divisor 0, detected in IDLE: the block SHALL skip DIV and FIX, go directly to DONE, and set out_hi=dividend (raw), out_lo=0xFFFFFFFF, out_div_zero=1.
REQ-027 out_div_zero SHALL be cleared at the start of any other operation.
REQ-028 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0 with no exception flag.
REQ-029 in_start outside IDLE SHALL be ignored.
REQ-030 in_start in DONE SHALL be ignored; the requester re-issues the request after DONE.
REQ-031 in_flush SHALL have priority over all transitions: the block returns to IDLE on the next edge with no out_done pulse.
REQ-032 in_flush SHALL leave out_hi, out_lo and out_div_zero at their previous values.
REQ-033 in_flush in IDLE SHALL also suppress a simultaneous in_start.
REQ-034 out_hi and out_lo SHALL change only in FIX, or on the divide-by-zero path, and SHALL hold otherwise.

Reset
REQ-035 While in_rst=0, the state SHALL be IDLE, the counter and the accumulator SHALL be 0, and out_hi, out_lo, out_done, out_busy and out_div_zero SHALL be 0.
REQ-036 out_stall SHALL be 0 regardless of in_start while in reset.
REQ-037 Reset asserted mid-operation SHALL abort immediately, with no out_done pulse.
REQ-038 The first in_start sampled after in_rst rises SHALL be accepted normally.

Verification
REQ-039 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> out_done 34 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, out_stall high for cycles 0-32.
REQ-040 MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-041 DIVU 10 / 0 -> out_done 1 cycle after start, hi=0x0000000A, lo=0xFFFFFFFF, out_div_zero=1; a following MULTU 2x3 -> flag 0, lo=6.
REQ-042 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, out_div_zero=0.
REQ-043 in_start pulsed at cycle 10 of a MULT -> ignored: single out_done at cycle 34 with the first result; in_flush at cycle 20 of another op -> IDLE at cycle 21, no done, hi/lo unchanged.
REQ-044 in_rst driven low at cycle 15 of a DIVU -> all outputs 0 asynchronously; after release, DIVU 100 / 7 -> lo=14, hi=2 at cycle 34.
